// File: rtl/ser_pkg.sv
// Shared types and constants for the serial frame driver.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
package ser_pkg;

    // FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter must reach WIDTH when the parity bit is appended
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// MSB-first shifter with bit counter for one frame.
// With SER_PARITY_EN defined, the word's XOR is captured at load time and driven after the LSB.
module ser_shift_reg
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    output logic             msb_o,
    output logic             last_o
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef SER_PARITY_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Load restarts the frame; shift advances one bit
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Shifter state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

`ifdef SER_PARITY_EN
    logic parity_q;

    // Parity is fixed at load so the trailer bit matches the word being sent
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^load_data_i;
        end
    end

    assign msb_o = last_o ? parity_q : sreg_q[WIDTH-1];
`else
    assign msb_o = sreg_q[WIDTH-1];
`endif

endmodule

// File: rtl/serial_frame_driver.sv
// Parallel-to-serial feeder: valid/ready intake, one holding register for gapless
// back-to-back frames, MSB-first bit stream on x. Idle level is 0.
// Defining SER_PARITY_EN appends an even-parity bit to every frame.
module serial_frame_driver
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             last;
    logic             frame_end;
    logic             shifter_free;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] load_data;
    logic             msb;

    assign data_ready   = !hold_full_q;
    assign accept       = data_valid && data_ready;
    assign frame_end    = (state_q == SHIFT) && last;
    assign shifter_free = (state_q == IDLE) || (frame_end && !hold_full_q);

    // Intake routing, hold register and FSM next state
    always_comb begin
        load        = 1'b0;
        load_data   = data_in;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        state_d     = state_q;
        shift       = (state_q == SHIFT) && !last;
        if (frame_end && hold_full_q) begin
            // Held word follows immediately; no accept possible as ready is low
            load        = 1'b1;
            load_data   = hold_q;
            hold_full_d = 1'b0;
        end else if (accept && shifter_free) begin
            load    = 1'b1;
            state_d = SHIFT;
        end else if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
        if (frame_end && !load) begin
            state_d = IDLE;
        end
    end

    // Handshake and FSM state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    ser_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load),
        .load_data_i (load_data),
        .shift_i     (shift),
        .msb_o       (msb),
        .last_o      (last)
    );

    assign x       = (state_q == SHIFT) ? msb : 1'b0;
    assign x_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_frame_driver.sv
// Directed bench for serial_frame_driver (WIDTH=8), default or SER_PARITY_EN build.
module tb_serial_frame_driver;

    localparam int unsigned WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_driver #(
        .WIDTH (WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_x"}, {31'd0, x}, 32'd0);
        check({tag, "_xv"}, {31'd0, x_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
    endtask

    // Expected serial bit at position pos of a frame carrying w
    function automatic logic frame_bit(input logic [7:0] w, input int pos);
        if (pos < 8) return w[7-pos];
        return ^w;
    endfunction

    // Single word with a one-cycle valid; par is the hand-computed trailer bit
    task automatic send_word(input logic [7:0] w, input logic par);
        logic eb;
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 8'h00;
        for (int i = 0; i < FRAME; i++) begin
            eb = (i < 8) ? w[7-i] : par;
            check("word_x", {31'd0, x}, {31'd0, eb});
            check("word_xv", {31'd0, x_valid}, 32'd1);
            tick();
        end
        check_idle("word_end");
    endtask

    logic [7:0] words [3];
    logic [3:0] hist;
    logic       det;
    logic       exp_rdy;

    initial begin
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Single word A5: 1,0,1,0,0,1,0,1
        send_word(8'hA5, 1'b0);

        // Back-to-back A5 then 0F
        words[0]   = 8'hA5;
        words[1]   = 8'h0F;
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick();
        for (int j = 0; j < 2 * FRAME; j++) begin
            check("b2b_x", {31'd0, x}, {31'd0, frame_bit(words[j / FRAME], j % FRAME)});
            check("b2b_xv", {31'd0, x_valid}, 32'd1);
            exp_rdy = !(j >= 1 && j < FRAME);
            check("b2b_ready", {31'd0, data_ready}, {31'd0, exp_rdy});
            if (j == 0) data_in = 8'h0F;
            if (j == 1) data_valid = 1'b0;
            tick();
        end
        check_idle("b2b_end");

        // Backpressure: 01, 02, 03 offered continuously
        words[0]   = 8'h01;
        words[1]   = 8'h02;
        words[2]   = 8'h03;
        data_in    = 8'h01;
        data_valid = 1'b1;
        tick();
        for (int j = 0; j < 3 * FRAME; j++) begin
            check("bp_x", {31'd0, x}, {31'd0, frame_bit(words[j / FRAME], j % FRAME)});
            check("bp_xv", {31'd0, x_valid}, 32'd1);
            exp_rdy = !((j >= 1 && j < FRAME) || (j >= FRAME + 1 && j < 2 * FRAME));
            check("bp_ready", {31'd0, data_ready}, {31'd0, exp_rdy});
            if (j == 0) data_in = 8'h02;
            if (j == 1) data_in = 8'h03;
            if (j == FRAME + 1) data_valid = 1'b0;
            tick();
        end
        check_idle("bp_end");

        // Reset mid-word: FF in flight, 55 held
        data_in    = 8'hFF;
        data_valid = 1'b1;
        tick();
        data_in = 8'h55;
        tick();
        data_valid = 1'b0;
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        check("rst_pre_ready", {31'd0, data_ready}, 32'd0);
        tick();
        check("rst_pre_x", {31'd0, x}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_mid");
        tick();
        check_idle("rst_after");
        send_word(8'hC3, 1'b0);

        // Detector link: reference 1010 overlap detector on the serial stream
        hist = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            det = ({hist[2:0], x} == 4'b1010);
            check("det_idle", {31'd0, det}, 32'd0);
            hist = {hist[2:0], x};
            tick();
        end
        data_in    = 8'hAA;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 1; i <= FRAME; i++) begin
            det = ({hist[2:0], x} == 4'b1010);
            check("det_hit", {31'd0, det}, {31'd0, (i == 4 || i == 6 || i == 8)});
            hist = {hist[2:0], x};
            tick();
        end
        check_idle("det_end");

        // Parity trailers: A5 -> 0, A4 -> 1 (only driven when parity is built in)
        send_word(8'hA5, 1'b0);
        send_word(8'hA4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
